// File: rtl/bj_pkg.sv
// Shared types and constants for the BlackJack agent: card layout, action and
// reward encodings, observation field offsets and the agent state enum.
package bj_pkg;

    localparam int CARD_WL             = 4;
    localparam int PLAYER_MAX_CARD_NUM = 21;
    localparam int DEALER_MAX_CARD_NUM = 17;
    localparam int MAX_SUM             = 31;
    localparam int SUM_WL              = 5;
    localparam int PLAYER_BITS         = PLAYER_MAX_CARD_NUM * CARD_WL;

    localparam int SUM_LSB   = 5;
    localparam int DCARD_LSB = 1;
    localparam int ACE_BIT   = 0;

    localparam logic ACT_HIT   = 1'b1;
    localparam logic ACT_STICK = 1'b0;

    localparam logic [1:0] RWD_WIN  = 2'b01;
    localparam logic [1:0] RWD_LOSE = 2'b11;
    localparam logic [1:0] RWD_DRAW = 2'b00;
    localparam logic [1:0] RWD_ERR  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DECIDE,
        ST_STEP,
        ST_GAP,
        ST_FINISH
    } agent_state_e;

    function automatic logic [SUM_WL-1:0] sat_sum(input logic [8:0] total);
        if (total > 9'(MAX_SUM)) begin
            return SUM_WL'(MAX_SUM);
        end
        return total[SUM_WL-1:0];
    endfunction

endpackage

// File: rtl/bj_hand_sum.sv
// Combinational player hand total: sums up to 21 packed 4-bit cards, promotes
// one ace to 11 when that keeps the hand at or below 21, saturates at 31.
module bj_hand_sum
    import bj_pkg::*;
(
    input  logic [PLAYER_BITS-1:0] i_cards,
    output logic [SUM_WL-1:0]      o_sum,
    output logic                   o_usable_ace
);

    logic [8:0] raw_total;
    logic       has_ace;

    always_comb begin
        raw_total = '0;
        has_ace   = 1'b0;
        for (int i = 0; i < PLAYER_MAX_CARD_NUM; i++) begin
            raw_total = raw_total + 9'(i_cards[i*CARD_WL +: CARD_WL]);
            if (i_cards[i*CARD_WL +: CARD_WL] == 4'd1) begin
                has_ace = 1'b1;
            end
        end
        o_usable_ace = has_ace && (raw_total <= 9'd11);
        o_sum        = sat_sum(o_usable_ace ? raw_total + 9'd10 : raw_total);
    end

endmodule

// File: rtl/bj_agent_driver.sv
// Fixed-threshold BlackJack agent: loads dealt hands, steps the environment
// until each episode ends, tallies results. Define BJ_AGENT_WATCHDOG_EN for a per-step timeout.
module bj_agent_driver
    import bj_pkg::*;
#(
    parameter int STA_WL       = 160,
    parameter int ACT_WL       = 1,
    parameter int OBS_WL       = 32,
    parameter int RWD_WL       = 2,
    parameter int STICK_THRESH = 17,
    parameter int EP_WL        = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [EP_WL-1:0]  i_num_episodes,
    input  logic              i_init_valid,
    output logic              o_init_ready,
    input  logic [STA_WL-1:0] i_init_sta,
    output logic              o_env_ena,
    output logic [STA_WL-1:0] o_env_sta,
    output logic [ACT_WL-1:0] o_env_act,
    input  logic [STA_WL-1:0] i_env_sta,
    input  logic [OBS_WL-1:0] i_env_obs,
    input  logic [RWD_WL-1:0] i_env_rwd,
    input  logic              i_env_done,
    input  logic              i_env_valid,
    output logic [EP_WL-1:0]  o_wins,
    output logic [EP_WL-1:0]  o_losses,
    output logic [EP_WL-1:0]  o_draws,
    output logic [EP_WL-1:0]  o_errors,
    output logic              o_busy,
    output logic              o_batch_done
);

    localparam logic [SUM_WL:0] THRESH = (SUM_WL+1)'(STICK_THRESH);

    function automatic logic [EP_WL-1:0] sat_inc(input logic [EP_WL-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    agent_state_e      state_q;
    logic [EP_WL-1:0]  rem_q, rem_dec_d;
    logic [STA_WL-1:0] sta_q;
    logic [SUM_WL-1:0] sum_q;
    logic [ACT_WL-1:0] act_q, act_d;
    logic              done_q;
    logic              ena_q, init_ready_q, busy_q, batch_done_q;
    logic [EP_WL-1:0]  wins_q, losses_q, draws_q, errors_q;
    logic [EP_WL-1:0]  wins_d, losses_d, draws_d, errors_d;

    logic [SUM_WL-1:0] init_sum;
    logic              init_ace;

    bj_hand_sum u_hand_sum (
        .i_cards      (i_init_sta[PLAYER_BITS-1:0]),
        .o_sum        (init_sum),
        .o_usable_ace (init_ace)
    );

`ifdef BJ_AGENT_WATCHDOG_EN
    localparam int WD_WL = $clog2(TIMEOUT + 1);
    logic [WD_WL-1:0] wdog_q;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    // Dealer cards, dealer-card and ace obs fields are not needed by this policy.
    logic unused_bits;
    assign unused_bits = ^{i_init_sta[STA_WL-1:PLAYER_BITS], init_ace,
                           i_env_obs[OBS_WL-1:SUM_LSB+SUM_WL], i_env_obs[SUM_LSB-1:0]};

    always_comb begin
        act_d     = ({1'b0, sum_q} < THRESH) ? ACT_WL'(ACT_HIT) : ACT_WL'(ACT_STICK);
        rem_dec_d = (rem_q == '0) ? '0 : rem_q - 1'b1;
        wins_d    = wins_q;
        losses_d  = losses_q;
        draws_d   = draws_q;
        errors_d  = errors_q;
        if (i_env_done) begin
            case (i_env_rwd)
                RWD_WIN:  wins_d   = sat_inc(wins_q);
                RWD_LOSE: losses_d = sat_inc(losses_q);
                RWD_DRAW: draws_d  = sat_inc(draws_q);
                default:  errors_d = sat_inc(errors_q);
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            sta_q        <= '0;
            act_q        <= '0;
            done_q       <= 1'b0;
            ena_q        <= 1'b0;
            init_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            batch_done_q <= 1'b0;
            wins_q       <= '0;
            losses_q     <= '0;
            draws_q      <= '0;
            errors_q     <= '0;
`ifdef BJ_AGENT_WATCHDOG_EN
            wdog_q       <= '0;
`endif
        end else begin
            batch_done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        rem_q    <= i_num_episodes;
                        wins_q   <= '0;
                        losses_q <= '0;
                        draws_q  <= '0;
                        errors_q <= '0;
                        busy_q   <= 1'b1;
                        if (i_num_episodes == '0) begin
                            state_q      <= ST_FINISH;
                            batch_done_q <= 1'b1;
                        end else begin
                            state_q      <= ST_LOAD;
                            init_ready_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (i_init_valid) begin
                        sta_q        <= i_init_sta;
                        sum_q        <= init_sum;
                        init_ready_q <= 1'b0;
                        state_q      <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    act_q   <= act_d;
                    ena_q   <= 1'b1;
                    state_q <= ST_STEP;
`ifdef BJ_AGENT_WATCHDOG_EN
                    wdog_q  <= '0;
`endif
                end
                // sta/act stay frozen here: any change would restart the env's dealer round.
                ST_STEP: begin
                    if (i_env_valid) begin
                        sta_q    <= i_env_sta;
                        sum_q    <= i_env_obs[SUM_LSB +: SUM_WL];
                        done_q   <= i_env_done;
                        wins_q   <= wins_d;
                        losses_q <= losses_d;
                        draws_q  <= draws_d;
                        errors_q <= errors_d;
                        if (i_env_done) begin
                            rem_q <= rem_dec_d;
                        end
                        ena_q   <= 1'b0;
                        state_q <= ST_GAP;
                    end
`ifdef BJ_AGENT_WATCHDOG_EN
                    else if (wdog_q == WD_WL'(TIMEOUT - 1)) begin
                        errors_q <= sat_inc(errors_q);
                        done_q   <= 1'b1;
                        rem_q    <= rem_dec_d;
                        ena_q    <= 1'b0;
                        state_q  <= ST_GAP;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end
                ST_GAP: begin
                    if (!done_q) begin
                        state_q <= ST_DECIDE;
                    end else if (rem_q != '0) begin
                        state_q      <= ST_LOAD;
                        init_ready_q <= 1'b1;
                    end else begin
                        state_q      <= ST_FINISH;
                        batch_done_q <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_init_ready = init_ready_q;
    assign o_env_ena    = ena_q;
    assign o_env_sta    = sta_q;
    assign o_env_act    = act_q;
    assign o_wins       = wins_q;
    assign o_losses     = losses_q;
    assign o_draws      = draws_q;
    assign o_errors     = errors_q;
    assign o_busy       = busy_q;
    assign o_batch_done = batch_done_q;

endmodule
